// File: rtl/inst_axi_rd_bridge_if.sv
// AXI4 read-channel bundle (AR + R) between the fetch bridge
// and the system crossbar. master = bridge side, slave = memory side.
//
// Signals:
//   ar*  : read address channel (arid/araddr/arlen/arsize/arburst/
//          arcache/arprot/arvalid from master, arready from slave)
//   r*   : read data channel (rid/rdata/rresp/rlast/rvalid from
//          slave, rready from master)
interface inst_axi_rd_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp,
    input  rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp,
    output rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: SRAM-like IF port -> single-beat AXI reads.
// One AR per accepted request, one data_ok per R beat, in order.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req, addr  : fetch request, held until addr_ok
//   addr_ok    : AR handshake this cycle (combinational pulse)
//   data_ok    : instruction word valid on rdata_o (1-cycle pulse)
//   rdata_o    : last returned instruction word
//   bus_err    : sticky error (bad RRESP, missing RLAST, orphan beat)
//   axi        : AXI read master (AR/R channels)
module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter int         CNT_W           = 2,
  parameter logic [3:0] ARID_VAL        = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata_o,
  output logic        bus_err,
  inst_axi_rd_bridge_if.master axi
);

  typedef enum logic {
    AR_IDLE,
    AR_WAIT
  } ar_state_e;

  ar_state_e        state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             arvalid_q, arvalid_d;
  logic [CNT_W-1:0] cnt_q;
  logic             can_issue;
  logic             ar_hs;
  logic             r_hs;
  logic             r_ok;
  logic             r_bad;
  logic             unused_rid;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = 1'b1;

  // Single ID, in-order slave: rid carries no information.
  assign unused_rid = ^axi.rid;

  assign can_issue = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign ar_hs     = (state_q == AR_WAIT) & axi.arready;
  assign addr_ok   = ar_hs;
  assign r_hs      = axi.rvalid & axi.rready;
  // A beat with nothing outstanding is dropped, not returned.
  assign r_ok      = r_hs & (cnt_q != '0);
  assign r_bad     = (cnt_q == '0)
                   | (axi.rresp != 2'b00)
                   | ~axi.rlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= AR_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  // Req is not re-checked in AR_WAIT: a started AR always completes.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    unique case (state_q)
      AR_IDLE: begin
        if (req && can_issue) begin
          araddr_d  = addr;
          arvalid_d = 1'b1;
          state_d   = AR_WAIT;
        end
      end
      AR_WAIT: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = AR_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ar_hs && !r_ok) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (r_ok && !ar_hs) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_ok <= 1'b0;
      rdata_o <= '0;
      bus_err <= 1'b0;
    end else begin
      data_ok <= r_ok;
      if (r_ok) begin
        rdata_o <= axi.rdata;
      end
      if (r_hs && r_bad) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule
